// File: rtl/pipelined_addsub_nbit.sv
// Pipelined WIDTH-bit two's-complement adder/subtractor, CHUNK bits resolved per stage.
// Latency: a beat accepted at edge N is presented on o_* after edge N+STAGES-1.
// Backpressure: the whole pipe freezes while o_valid && !i_ready; o_ready = !o_valid || i_ready.
//
// Ports:
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_valid/o_ready             operand handshake (i_A, i_B, i_Cin, i_sub)
//   o_valid/i_ready             result handshake (o_sum, o_carry, o_overflow, o_zero)
//   i_sub                       0 = A + B + Cin, 1 = A - B - Cin (Cin acts as borrow-in)
//   o_carry                     carry out of the MSB; in subtract mode 1 means "no borrow"
//
// WIDTH must be a non-zero multiple of CHUNK.
module pipelined_addsub_nbit #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    input  logic             i_Cin,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_overflow,
    output logic             o_zero
);

    localparam int STAGES = WIDTH / CHUNK;

    // Single shared advance enable: bubbles are not squeezed out, so one gate
    // from i_ready to o_ready is the only combinational input->output path.
    logic adv;
    assign adv     = !o_valid || i_ready;
    assign o_ready = adv;

    // Subtraction is folded in up front as A + ~B + ~Cin, so every stage is a plain adder.
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    assign b_eff   = i_sub ? ~i_B : i_B;
    assign cin_eff = i_sub ? ~i_Cin : i_Cin;

    genvar k;
    for (k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits not yet summed on entry to this stage, and result bits
        // that exist once this stage has added its chunk.
        localparam int RW = WIDTH - k * CHUNK;
        localparam int DW = (k + 1) * CHUNK;

        logic          vld_in;
        logic          cin;
        logic [RW-1:0] a_in;
        logic [RW-1:0] b_in;
        logic [CHUNK:0] part;
        logic [DW-1:0] sum_nxt;

        logic          vld_q;
        logic          c_q;
        logic [DW-1:0] sum_q;

        if (k == 0) begin : g_first
            assign vld_in  = i_valid;
            assign a_in    = i_A;
            assign b_in    = b_eff;
            assign cin     = cin_eff;
            assign sum_nxt = part[CHUNK-1:0];
        end else begin : g_next
            assign vld_in  = g_stage[k-1].vld_q;
            assign a_in    = g_stage[k-1].g_fwd.a_q;
            assign b_in    = g_stage[k-1].g_fwd.b_q;
            assign cin     = g_stage[k-1].c_q;
            assign sum_nxt = {part[CHUNK-1:0], g_stage[k-1].sum_q};
        end

        // Ripple add of this stage's chunk; the top bit becomes the next stage's carry.
        assign part = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]} + {{CHUNK{1'b0}}, cin};

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                vld_q <= 1'b0;
                c_q   <= 1'b0;
                sum_q <= '0;
            end else if (adv) begin
                vld_q <= vld_in;
                c_q   <= part[CHUNK];
                sum_q <= sum_nxt;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            // Only the still-unsummed upper operand bits travel onward.
            logic [RW-CHUNK-1:0] a_q;
            logic [RW-CHUNK-1:0] b_q;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_in[RW-1:CHUNK];
                    b_q <= b_in[RW-1:CHUNK];
                end
            end
        end else begin : g_last
            // The MSB operand bits are only available here, so the flags are
            // formed in this stage and registered alongside the final sum.
            logic ovf_q;
            logic zero_q;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (adv) begin
                    ovf_q  <= (a_in[RW-1] == b_in[RW-1]) && (sum_nxt[DW-1] != a_in[RW-1]);
                    zero_q <= (sum_nxt == '0);
                end
            end
        end
    end

    assign o_valid    = g_stage[STAGES-1].vld_q;
    assign o_sum      = g_stage[STAGES-1].sum_q;
    assign o_carry    = g_stage[STAGES-1].c_q;
    assign o_overflow = g_stage[STAGES-1].g_last.ovf_q;
    assign o_zero     = g_stage[STAGES-1].g_last.zero_q;

endmodule

// File: tb/tb_pipelined_addsub_nbit.sv
// Bench for pipelined_addsub_nbit: directed arithmetic/flag cases, streaming with a stall,
// mid-flight reset, and random sweeps on the 4/4 and 32/8 configurations.
module tb_pipelined_addsub_nbit;

    typedef struct packed {
        logic [31:0] sum;
        logic        c;
        logic        v;
        logic        z;
        int          t;
    } res_t;

    int n_checks = 0;
    int n_pass   = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- 16/4 instance ----------------
    logic        m_valid = 0, m_cin = 0, m_sub = 0, m_irdy = 1;
    logic [15:0] m_a = 0, m_b = 0;
    logic        m_rdy, m_ovld, m_c, m_v, m_z;
    logic [15:0] m_sum;
    res_t        exp_m[$], got_m[$];
    int          m_cyc = 0;

    pipelined_addsub_nbit #(.WIDTH(16), .CHUNK(4)) u_dut16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(m_valid), .o_ready(m_rdy),
        .i_A(m_a), .i_B(m_b), .i_Cin(m_cin), .i_sub(m_sub),
        .o_valid(m_ovld), .i_ready(m_irdy), .o_sum(m_sum),
        .o_carry(m_c), .o_overflow(m_v), .o_zero(m_z));

    // ---------------- 4/4 instance ----------------
    logic        s4_valid = 0, s4_cin = 0, s4_sub = 0, s4_irdy = 1;
    logic [3:0]  s4_a = 0, s4_b = 0;
    logic        s4_rdy, s4_ovld, s4_c, s4_v, s4_z;
    logic [3:0]  s4_sum;
    res_t        exp_4[$], got_4[$];
    int          s4_cyc = 0;

    pipelined_addsub_nbit #(.WIDTH(4), .CHUNK(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(s4_valid), .o_ready(s4_rdy),
        .i_A(s4_a), .i_B(s4_b), .i_Cin(s4_cin), .i_sub(s4_sub),
        .o_valid(s4_ovld), .i_ready(s4_irdy), .o_sum(s4_sum),
        .o_carry(s4_c), .o_overflow(s4_v), .o_zero(s4_z));

    // ---------------- 32/8 instance ----------------
    logic        s32_valid = 0, s32_cin = 0, s32_sub = 0, s32_irdy = 1;
    logic [31:0] s32_a = 0, s32_b = 0;
    logic        s32_rdy, s32_ovld, s32_c, s32_v, s32_z;
    logic [31:0] s32_sum;
    res_t        exp_32[$], got_32[$];
    int          s32_cyc = 0;

    pipelined_addsub_nbit #(.WIDTH(32), .CHUNK(8)) u_dut32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(s32_valid), .o_ready(s32_rdy),
        .i_A(s32_a), .i_B(s32_b), .i_Cin(s32_cin), .i_sub(s32_sub),
        .o_valid(s32_ovld), .i_ready(s32_irdy), .o_sum(s32_sum),
        .o_carry(s32_c), .o_overflow(s32_v), .o_zero(s32_z));

    // Reference: whole-word arithmetic at width w, flags from the operand/result MSBs.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub, input int w);
        res_t        r;
        logic [63:0] mask, aa, bb, full;
        logic        ci;
        mask   = (64'd1 << w) - 64'd1;
        aa     = {32'h0, a} & mask;
        bb     = (sub ? ~{32'h0, b} : {32'h0, b}) & mask;
        ci     = sub ? ~cin : cin;
        full   = aa + bb + {63'd0, ci};
        r.sum  = full[31:0] & mask[31:0];
        r.c    = full[w];
        r.v    = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
        r.z    = ((full & mask) == 64'd0);
        r.t    = 0;
        return r;
    endfunction

    // One cycle: sample handshakes #1 after the falling edge (inputs already driven),
    // record accepted beats as expectations and delivered beats as observations.
    task automatic step_m(output logic acc, output logic rdy_s, output logic vld_s,
                          output logic [15:0] sum_s);
        res_t r;
        #1;
        acc   = m_valid && m_rdy;
        rdy_s = m_rdy;
        vld_s = m_ovld;
        sum_s = m_sum;
        if (acc) begin
            r = model({16'h0, m_a}, {16'h0, m_b}, m_cin, m_sub, 16);
            r.t = m_cyc;
            exp_m.push_back(r);
        end
        if (m_ovld && m_irdy) begin
            r.sum = {16'h0, m_sum}; r.c = m_c; r.v = m_v; r.z = m_z; r.t = m_cyc;
            got_m.push_back(r);
        end
        m_cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step_4(output logic acc);
        res_t r;
        #1;
        acc = s4_valid && s4_rdy;
        if (acc) begin
            r = model({28'h0, s4_a}, {28'h0, s4_b}, s4_cin, s4_sub, 4);
            r.t = s4_cyc;
            exp_4.push_back(r);
        end
        if (s4_ovld && s4_irdy) begin
            r.sum = {28'h0, s4_sum}; r.c = s4_c; r.v = s4_v; r.z = s4_z; r.t = s4_cyc;
            got_4.push_back(r);
        end
        s4_cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step_32(output logic acc);
        res_t r;
        #1;
        acc = s32_valid && s32_rdy;
        if (acc) begin
            r = model(s32_a, s32_b, s32_cin, s32_sub, 32);
            r.t = s32_cyc;
            exp_32.push_back(r);
        end
        if (s32_ovld && s32_irdy) begin
            r.sum = s32_sum; r.c = s32_c; r.v = s32_v; r.z = s32_z; r.t = s32_cyc;
            got_32.push_back(r);
        end
        s32_cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_m(input int n);
        logic acc, rs, vs;
        logic [15:0] ss;
        m_valid = 1'b0;
        for (int i = 0; i < n; i++) step_m(acc, rs, vs, ss);
    endtask

    task automatic send_m(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic sub);
        logic acc, rs, vs;
        logic [15:0] ss;
        m_a = a; m_b = b; m_cin = cin; m_sub = sub; m_valid = 1'b1;
        step_m(acc, rs, vs, ss);
        m_valid = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (m_ovld !== 1'b0) $display("FAIL reset_valid got=%b want=0", m_ovld); else n_pass++;
        n_checks++; if (m_sum !== 16'h0) $display("FAIL reset_sum got=%h want=0000", m_sum); else n_pass++;
        n_checks++; if ({m_c, m_v, m_z} !== 3'b000) $display("FAIL reset_flags got=%b want=000", {m_c, m_v, m_z}); else n_pass++;
        n_checks++; if (m_rdy !== 1'b1) $display("FAIL reset_ready got=%b want=1", m_rdy); else n_pass++;
        n_checks++; if ({s4_ovld, s32_ovld} !== 2'b00) $display("FAIL reset_sweep_valid got=%b want=00", {s4_ovld, s32_ovld}); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add_sub_flags();
        logic [15:0] ta[6], tb[6], ts[6];
        logic        tc[6], tsub[6];
        logic [2:0]  tf[6];
        ta = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h0003, 16'h8000, 16'h0010};
        tb = '{16'h0001, 16'h0001, 16'h0001, 16'h0005, 16'h0001, 16'h0001};
        tc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tsub = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        ts = '{16'h0100, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF, 16'h000E};
        // {carry, overflow, zero}
        tf = '{3'b000, 3'b101, 3'b010, 3'b000, 3'b110, 3'b100};
        m_irdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_m.delete(); got_m.delete();
            send_m(ta[i], tb[i], tc[i], tsub[i]);
            idle_m(8);
            n_checks++;
            if (got_m.size() != 1 || exp_m.size() != 1) begin
                $display("FAIL dir%0d_count got=%0d want=1", i, got_m.size());
            end else begin
                n_pass++;
                n_checks++;
                if (got_m[0].sum[15:0] !== ts[i]) $display("FAIL dir%0d_sum got=%h want=%h", i, got_m[0].sum[15:0], ts[i]); else n_pass++;
                n_checks++;
                if ({got_m[0].c, got_m[0].v, got_m[0].z} !== tf[i])
                    $display("FAIL dir%0d_flags got=%b want=%b", i, {got_m[0].c, got_m[0].v, got_m[0].z}, tf[i]);
                else n_pass++;
                n_checks++;
                if (got_m[0].t - exp_m[0].t != 4) $display("FAIL dir%0d_latency got=%0d want=4", i, got_m[0].t - exp_m[0].t); else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ba[8], bb[8];
        logic        bc[8], bs[8];
        logic        acc, rs, vs, prev_stall, stalled, ir;
        logic [15:0] ss, prev_sum;
        int          j;
        res_t        g, e;
        for (int i = 0; i < 8; i++) begin
            ba[i] = 16'($urandom); bb[i] = 16'($urandom);
            bc[i] = 1'($urandom); bs[i] = 1'($urandom);
        end
        exp_m.delete(); got_m.delete();
        j = 0; prev_stall = 1'b0; prev_sum = '0;
        for (int s = 0; s < 60 && got_m.size() < 8; s++) begin
            if (j < 8) begin
                m_valid = 1'b1; m_a = ba[j]; m_b = bb[j]; m_cin = bc[j]; m_sub = bs[j];
            end else begin
                m_valid = 1'b0;
            end
            ir = !(s >= 5 && s <= 7);
            m_irdy = ir;
            step_m(acc, rs, vs, ss);
            stalled = vs && !ir;
            n_checks++;
            if (rs !== !stalled) $display("FAIL b2b_ready s=%0d got=%b want=%b", s, rs, !stalled); else n_pass++;
            if (stalled && prev_stall) begin
                n_checks++;
                if (ss !== prev_sum) $display("FAIL b2b_stall_hold s=%0d got=%h want=%h", s, ss, prev_sum); else n_pass++;
            end
            prev_stall = stalled; prev_sum = ss;
            if (acc) j++;
        end
        m_valid = 1'b0; m_irdy = 1'b1;
        n_checks++;
        if (got_m.size() != 8 || exp_m.size() != 8)
            $display("FAIL b2b_count got=%0d accepted=%0d want=8", got_m.size(), exp_m.size());
        else n_pass++;
        while (got_m.size() > 0 && exp_m.size() > 0) begin
            g = got_m.pop_front(); e = exp_m.pop_front();
            n_checks++;
            if ({g.sum, g.c, g.v, g.z} !== {e.sum, e.c, e.v, e.z})
                $display("FAIL b2b_result got=%h/%b want=%h/%b", g.sum, {g.c, g.v, g.z}, e.sum, {e.c, e.v, e.z});
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic acc, rs, vs;
        logic [15:0] ss;
        m_irdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_valid = 1'b1; m_a = 16'(16'h0101 * i); m_b = 16'h0F0F; m_cin = 1'b1; m_sub = 1'b0;
            step_m(acc, rs, vs, ss);
        end
        m_valid = 1'b0;
        #1;
        n_checks++; if (m_ovld !== 1'b1) $display("FAIL rstmid_prefill_valid got=%b want=1", m_ovld); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (m_ovld !== 1'b0) $display("FAIL rstmid_valid got=%b want=0", m_ovld); else n_pass++;
        n_checks++; if ({m_sum, m_c, m_v, m_z} !== 19'h0) $display("FAIL rstmid_outputs got=%h want=0", {m_sum, m_c, m_v, m_z}); else n_pass++;
        n_checks++; if (m_rdy !== 1'b1) $display("FAIL rstmid_ready got=%b want=1", m_rdy); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_irdy = 1'b1;
        exp_m.delete(); got_m.delete();
        idle_m(6);
        n_checks++; if (got_m.size() != 0) $display("FAIL rstmid_stale got=%0d want=0", got_m.size()); else n_pass++;
        send_m(16'h1234, 16'h1111, 1'b0, 1'b0);
        idle_m(8);
        n_checks++;
        if (got_m.size() != 1 || exp_m.size() != 1) begin
            $display("FAIL rstmid_fresh_count got=%0d want=1", got_m.size());
        end else begin
            n_pass++;
            n_checks++; if (got_m[0].sum[15:0] !== 16'h2345) $display("FAIL rstmid_fresh_sum got=%h want=2345", got_m[0].sum[15:0]); else n_pass++;
            n_checks++; if (got_m[0].t - exp_m[0].t != 4) $display("FAIL rstmid_fresh_latency got=%0d want=4", got_m[0].t - exp_m[0].t); else n_pass++;
        end
    endtask

    task automatic test_sweep_w4();
        logic acc;
        int   n_acc;
        res_t g, e;
        exp_4.delete(); got_4.delete();
        s4_irdy = 1'b1; s4_valid = 1'b1; s4_a = 4'h9; s4_b = 4'h8; s4_cin = 1'b1; s4_sub = 1'b0;
        step_4(acc);
        s4_valid = 1'b0;
        for (int i = 0; i < 4; i++) step_4(acc);
        n_checks++;
        if (got_4.size() != 1 || exp_4.size() != 1) $display("FAIL w4_latency_count got=%0d want=1", got_4.size());
        else if (got_4[0].t - exp_4[0].t != 1) $display("FAIL w4_latency got=%0d want=1", got_4[0].t - exp_4[0].t);
        else n_pass++;
        exp_4.delete(); got_4.delete();
        n_acc = 0;
        for (int s = 0; s < 8000 && (n_acc < 1000 || exp_4.size() > 0); s++) begin
            s4_valid = (n_acc < 1000) && ($urandom_range(0, 3) != 0);
            s4_irdy  = ($urandom_range(0, 3) != 0);
            s4_a = 4'($urandom); s4_b = 4'($urandom); s4_cin = 1'($urandom); s4_sub = 1'($urandom);
            step_4(acc);
            if (acc) n_acc++;
            while (got_4.size() > 0) begin
                g = got_4.pop_front();
                n_checks++;
                if (exp_4.size() == 0) begin
                    $display("FAIL w4_extra got=%h want=none", g.sum);
                end else begin
                    e = exp_4.pop_front();
                    if ({g.sum, g.c, g.v, g.z} !== {e.sum, e.c, e.v, e.z})
                        $display("FAIL w4_result got=%h/%b want=%h/%b", g.sum, {g.c, g.v, g.z}, e.sum, {e.c, e.v, e.z});
                    else n_pass++;
                end
            end
        end
        s4_valid = 1'b0; s4_irdy = 1'b1;
        n_checks++;
        if (n_acc != 1000 || exp_4.size() != 0) $display("FAIL w4_drain accepted=%0d pending=%0d want=1000/0", n_acc, exp_4.size()); else n_pass++;
    endtask

    task automatic test_sweep_w32();
        logic acc;
        int   n_acc;
        res_t g, e;
        exp_32.delete(); got_32.delete();
        s32_irdy = 1'b1; s32_valid = 1'b1; s32_a = 32'h00FF_FFFF; s32_b = 32'h0000_0001; s32_cin = 1'b0; s32_sub = 1'b0;
        step_32(acc);
        s32_valid = 1'b0;
        for (int i = 0; i < 8; i++) step_32(acc);
        n_checks++;
        if (got_32.size() != 1 || exp_32.size() != 1) $display("FAIL w32_latency_count got=%0d want=1", got_32.size());
        else if (got_32[0].t - exp_32[0].t != 4) $display("FAIL w32_latency got=%0d want=4", got_32[0].t - exp_32[0].t);
        else if (got_32[0].sum !== 32'h0100_0000) $display("FAIL w32_carry_chain got=%h want=01000000", got_32[0].sum);
        else n_pass++;
        exp_32.delete(); got_32.delete();
        n_acc = 0;
        for (int s = 0; s < 8000 && (n_acc < 1000 || exp_32.size() > 0); s++) begin
            s32_valid = (n_acc < 1000) && ($urandom_range(0, 3) != 0);
            s32_irdy  = ($urandom_range(0, 3) != 0);
            s32_a = $urandom; s32_b = $urandom; s32_cin = 1'($urandom); s32_sub = 1'($urandom);
            step_32(acc);
            if (acc) n_acc++;
            while (got_32.size() > 0) begin
                g = got_32.pop_front();
                n_checks++;
                if (exp_32.size() == 0) begin
                    $display("FAIL w32_extra got=%h want=none", g.sum);
                end else begin
                    e = exp_32.pop_front();
                    if ({g.sum, g.c, g.v, g.z} !== {e.sum, e.c, e.v, e.z})
                        $display("FAIL w32_result got=%h/%b want=%h/%b", g.sum, {g.c, g.v, g.z}, e.sum, {e.c, e.v, e.z});
                    else n_pass++;
                end
            end
        end
        s32_valid = 1'b0; s32_irdy = 1'b1;
        n_checks++;
        if (n_acc != 1000 || exp_32.size() != 0) $display("FAIL w32_drain accepted=%0d pending=%0d want=1000/0", n_acc, exp_32.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_add_sub_flags();
        test_back_to_back();
        test_reset_mid();
        test_sweep_w4();
        test_sweep_w32();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
